fixed_point_issue_unit: RTL
===========================

# fixed_point_issue_unit

Requester-side controller for the fixed-point unit. It sits in the execute stage between the pipeline and the fixed-point unit. It accepts one fixed-point instruction at a time over a valid/ready handshake, drives stable operation and operand lines to the unit, waits for the unit's `ready`, and returns the tagged result to writeback over a second valid/ready handshake. An optional watchdog bounds the wait.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `TIMEOUT`, 64: maximum WAIT cycles before an error response (watchdog builds only; must be ≥ 2).

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted this cycle when high together with `req_valid`.
- `req_op`  in  2: `FPU_ADD`/`FPU_SUB`/`FPU_MUL`/`FPU_SQRT` code from Defines.vh.
- `req_rd`  in  5: destination register tag.
- `req_operand_1`, `req_operand_2`  in  WIDTH: Q(WIDTH-10).10 operands.
- `fpu_operation`  out  2: to fixed-point unit.
- `fpu_operand_1`, `fpu_operand_2`  out  WIDTH: to fixed-point unit.
- `fpu_result`  in  WIDTH: from fixed-point unit.
- `fpu_ready`  in  1: from fixed-point unit; may be combinational.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: writeback accepts.
- `rsp_rd`  out  5: tag of completed op.
- `rsp_result`  out  WIDTH: captured result.
- `rsp_error`  out  1: watchdog expired.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready`=1; `fpu_operation`=`FPU_ADD`; `fpu_operands`=0. This is the neutral drive, so the unit's MUL sequencer never self-triggers.
  - On `req_valid`, capture op, rd and operands, then go to ISSUE.
- ISSUE:
  - Drive the captured op and operands. `fpu_ready` is ignored, because it may be stale from the previous op.
  - Always go to WAIT.
- WAIT:
  - Keep driving the captured op and operands.
  - When `fpu_ready` is high, register `fpu_result` into `rsp_result`, set `rsp_error`=0, go to RESP.
- RESP:
  - `rsp_valid`=1. Drive the neutral values to the FPU.
  - Hold `rsp_rd`, `rsp_result` and `rsp_error` stable until `rsp_ready`, then go to IDLE.
- `req_ready` is high only in IDLE. There is no overlap of a response with the next acceptance.
- Captured request fields do not change outside IDLE, whatever happens on the `req_*` inputs.
- Results pass through unmodified; no arithmetic is done in this block.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=1, `busy`=0, `rsp_valid`=0
  - `rsp_rd`=0, `rsp_result`=0, `rsp_error`=0
  - `fpu_operation`=`FPU_ADD`, `fpu_operands`=0
- Accept at edge N:
  - ISSUE during cycle N→N+1.
  - WAIT from N+1.
  - Earliest capture at edge N+2; `rsp_valid` high after N+2.
  - Minimum turnaround: 3 cycles acceptance→response, 4 cycles acceptance→next acceptance.
- WAIT of k cycles (`fpu_ready` first sampled high on the k-th WAIT edge) gives `rsp_valid` after edge N+1+k.
- A `rsp_valid`/`rsp_ready` handshake completes on the same edge that the state returns to IDLE.
- Reset mid-operation: everything returns to reset values immediately. In-flight op and response are discarded; no response is produced.
- `fpu_ready` high in ISSUE: ignored. It has no effect on the WAIT count.

## Configuration
- `FPU_ISSUE_TIMEOUT_EN` defined:
  - A WAIT cycle counter clears on entering WAIT.
  - If the counter reaches `TIMEOUT` WAIT cycles with no `fpu_ready`, go to RESP with `rsp_error`=1, `rsp_result`=0 and the captured `rsp_rd`.
  - If `fpu_ready` is high in the same cycle as expiry, the ready wins (normal response, `rsp_error`=0).
- Not defined:
  - No counter is built; WAIT is unbounded.
  - `rsp_error` is tied 0; `TIMEOUT` is unused.

## Test plan
The bench uses a behavioural FPU model with programmable latency L (cycles from ISSUE start to `fpu_ready`), and `rsp_ready` held high unless stated.
- ADD, op1=0x600 (1.5), op2=0x800 (2.0), model combinational ready -> `rsp_result`=0xE00, `rsp_rd`=tag, `rsp_valid` 3 cycles after acceptance, `rsp_error`=0.
- MUL, op1=0x600, op2=0x800, L=6 -> `rsp_result`=0xC00. `fpu_operation`=`FPU_MUL` stable throughout ISSUE/WAIT, then `FPU_ADD` in RESP. `req_ready` low until the response handshake completes.
- Stale ready: model asserts `fpu_ready` during ISSUE only, then again at L=4 -> result captured at the L=4 ready, not the ISSUE one.
- Backpressure: `rsp_ready` held low 5 cycles in RESP, with new `req_valid` and changed `req_*` inputs -> `rsp_result` and `rsp_rd` stable, no acceptance, captured request unchanged.
- Watchdog (`FPU_ISSUE_TIMEOUT_EN`, `TIMEOUT`=8): model never readies -> after 8 WAIT cycles, `rsp_valid`=1, `rsp_error`=1, `rsp_result`=0. Ready on the 8th cycle -> normal response with `rsp_error`=0.
- Reset asserted in WAIT -> same cycle: `busy`=0, `req_ready`=1, `fpu_operation`=`FPU_ADD`. No `rsp_valid` afterwards; the next request completes normally.

Source files
------------

// File: rtl/fixed_point_issue_unit.sv
// One-at-a-time issue controller between the execute stage and the fixed-point unit.
// Define FPU_ISSUE_TIMEOUT_EN to build a watchdog that bounds the WAIT state to TIMEOUT cycles.
module fixed_point_issue_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [4:0]       req_rd,
  input  logic [WIDTH-1:0] req_operand_1,
  input  logic [WIDTH-1:0] req_operand_2,
  output logic [1:0]       fpu_operation,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_rd,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_error,
  output logic             busy
);

  // Operation code matching FPU_ADD in Defines.vh; also the neutral drive.
  localparam logic [1:0] FPU_ADD = 2'b00;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] operand_1_q, operand_2_q;
  logic             expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    fpu_operation = FPU_ADD;
    fpu_operand_1 = '0;
    fpu_operand_2 = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        // A ready seen here may belong to the previous operation.
        fpu_operation = op_q;
        fpu_operand_1 = operand_1_q;
        fpu_operand_2 = operand_2_q;
        state_next    = WAIT;
      end
      WAIT: begin
        fpu_operation = op_q;
        fpu_operand_1 = operand_1_q;
        fpu_operand_2 = operand_2_q;
        if (fpu_ready || expire) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= FPU_ADD;
      rd_q        <= '0;
      operand_1_q <= '0;
      operand_2_q <= '0;
    end else if (state == IDLE && req_valid) begin
      op_q        <= req_op;
      rd_q        <= req_rd;
      operand_1_q <= req_operand_1;
      operand_2_q <= req_operand_2;
    end
  end

  // A timed-out operation reports a zero result under the captured tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rd     <= '0;
      rsp_result <= '0;
    end else if (state == WAIT && fpu_ready) begin
      rsp_rd     <= rd_q;
      rsp_result <= fpu_result;
    end else if (expire) begin
      rsp_rd     <= rd_q;
      rsp_result <= '0;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Ready on the expiry cycle takes priority over the timeout.
  assign expire = (state == WAIT) && !fpu_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            wait_cnt <= '0;
    else if (state == ISSUE)              wait_cnt <= '0;
    else if (state == WAIT && !fpu_ready) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            rsp_error <= 1'b0;
    else if (state == WAIT && fpu_ready)  rsp_error <= 1'b0;
    else if (expire)                      rsp_error <= 1'b1;
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign rsp_error      = 1'b0;
  assign unused_timeout = (TIMEOUT >= 2);
`endif

endmodule
